// File: rtl/ysyx_23060077_iter_div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package ysyx_23060077_iter_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ysyx_23060077_iter_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes at accept; one quotient bit is produced per cycle.
module ysyx_23060077_iter_div
    import ysyx_23060077_iter_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   part_shift;
    logic [WIDTH:0]   part_diff;
    logic             q_bit;

    // The stored remainder is always below the divisor, so the shifted value fits
    // WIDTH+1 bits and the top bit of the difference acts as the borrow.
    always_comb begin
        part_shift = {part_q, shreg_q[WIDTH-1]};
        part_diff  = part_shift - {1'b0, dvs_q};
        q_bit      = ~part_diff[WIDTH];
    end

    // NOTE: every *_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (div_valid && !flush) begin
                    q_neg_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = div_signed & dividend[WIDTH-1];
                    shreg_d = abs_val(dividend, div_signed);
                    dvs_d   = abs_val(divisor, div_signed);
                    part_d  = '0;
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        state_d = ST_DONE;
                    end else if (div_signed && dividend == MIN_NEG && divisor == '1) begin
                        quot_d  = MIN_NEG;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    part_d  = q_bit ? part_diff[WIDTH-1:0] : part_shift[WIDTH-1:0];
                    shreg_d = {shreg_q[WIDTH-2:0], q_bit};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        quot_d  = q_neg_q ? negate(shreg_d) : shreg_d;
                        rem_d   = r_neg_q ? negate(part_d) : part_d;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign div_ready = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE) && !flush;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_ysyx_23060077_iter_div.sv
// Self-checking bench: arithmetic reference model plus directed operations with literal results.
module tb_ysyx_23060077_iter_div;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        div_valid;
    logic        div_ready;
    logic        out_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    ysyx_23060077_iter_div #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RISC-V division semantics with the specified latency (1 for special cases, 33 otherwise).
    function automatic void model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r, output int lat);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; lat = 1;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
            lat = 33;
        end else begin
            q = a / b; r = a % b; lat = 33;
        end
    endfunction

    bit          m_init = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left;
    int          m_lat;
    logic [31:0] m_q, m_r, p_q, p_r;

    // Reference timeline: updated from inputs at each edge, compared just after it.
    always @(posedge clock) begin
        if (reset) begin
            m_init = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_q = 32'd0; m_r = 32'd0;
        end else if (m_init) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy) begin
                if (flush) m_busy = 1'b0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r;
                    end
                end
            end else if (div_valid && !flush) begin
                model_div(div_signed, dividend, divisor, p_q, p_r, m_lat);
                if (m_lat == 1) begin
                    m_done = 1'b1; m_q = p_q; m_r = p_r;
                end else begin
                    m_busy = 1'b1; m_left = m_lat - 1;
                end
            end
        end
        #1;
        if (m_init) begin
            check("model out_valid", 32'(out_valid), 32'(m_done && !flush));
            check("model div_ready", 32'(div_ready), 32'(!(m_busy || m_done)));
            check("model quotient", quotient, m_q);
            check("model remainder", remainder, m_r);
        end
    end

    task automatic run_op(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat, input bit hold);
        int lat;
        bit seen;
        @(negedge clock);
        for (int i = 0; i < 50 && !div_ready; i++) @(negedge clock);
        div_signed = sgn; dividend = a; divisor = b; div_valid = 1'b1;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock); #1;
            lat++;
            if (!hold) div_valid = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        div_valid = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        @(posedge clock); #1;
        check({name, " pulse width"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset div_ready", 32'(div_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        @(negedge clock) reset = 1'b0;

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
        run_op("div by zero s", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1'b0);
        run_op("div by zero u", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1'b0);
        run_op("overflow s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1, 1'b0);
        run_op("overflow u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b0);

        // Flush at iteration 10, then a fresh request.
        @(negedge clock);
        div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; div_valid = 1'b1;
        @(posedge clock); #1 div_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock) flush = 1'b1;
        @(posedge clock); #1;
        check("flush returns idle", 32'(div_ready), 32'd1);
        @(negedge clock) flush = 1'b0;
        run_op("after flush", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, 1'b0);

        // Flush in idle blocks acceptance.
        @(negedge clock);
        dividend = 32'd20; divisor = 32'd4; div_valid = 1'b1; flush = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("idle flush blocks", 32'(div_ready), 32'd1);
        @(negedge clock) begin div_valid = 1'b0; flush = 1'b0; end

        // div_valid held high through the whole operation: exactly one accept.
        run_op("held valid", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33, 1'b1);

        // Reset in the middle of an operation.
        @(negedge clock);
        dividend = 32'd90; divisor = 32'd9; div_valid = 1'b1;
        @(posedge clock);
        repeat (5) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        check("mid reset div_ready", 32'(div_ready), 32'd1);
        check("mid reset quotient", quotient, 32'd0);
        check("mid reset remainder", remainder, 32'd0);
        @(negedge clock) begin reset = 1'b0; div_valid = 1'b0; end
        repeat (40) @(posedge clock);

        run_op("back to back a", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("back to back b", 1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 33, 1'b0);

        repeat (3) @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
